// File: rtl/adapter_dl.sv
// Downlink CPRI-to-AXIS adapter: unpacks two-sample IQ words into one sample
// per beat through a small first-word-fall-through FIFO with overflow accounting.
module adapter_dl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  iq_rx_i,
  input  logic [31:0]                  iq_rx_q,
  input  logic                         iq_rx_valid,
  output logic [31:0]                  m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // A pair is only accepted when both halves are guaranteed a slot.
  localparam logic [LVL_W-1:0] ACCEPT_MAX = LVL_W'(FIFO_DEPTH - 2);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            r_state;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [31:0]       r_hold;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [31:0]       w_push_data;
  logic [31:0]       w_sample_a;
  logic [31:0]       w_sample_b;

  assign w_sample_a = {iq_rx_q[15:0],  iq_rx_i[15:0]};
  assign w_sample_b = {iq_rx_q[31:16], iq_rx_i[31:16]};
  assign w_pop      = (r_level != '0) && m_axis_tready;

  always_comb begin
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_push_data = r_hold;
    case (r_state)
      IDLE: begin
        if (iq_rx_valid) begin
          if (r_level <= ACCEPT_MAX) begin
            w_push      = 1'b1;
            w_push_data = w_sample_a;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      SECOND: begin
        // The held B always goes in; a strobe arriving now is too close and is lost.
        w_push = 1'b1;
        w_drop = iq_rx_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_hold     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) begin
            r_hold  <= w_sample_b;
            r_state <= SECOND;
          end
        end
        SECOND:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: ;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign m_axis_tvalid = (r_level != '0);
  assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level    = r_level;
  assign overflow      = r_overflow;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_adapter_dl.sv
// Bench for adapter_dl: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based sample-flow model.
module tb_adapter_dl;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic           clk;
  logic           rst;
  logic [31:0]    iq_rx_i;
  logic [31:0]    iq_rx_q;
  logic           iq_rx_valid;
  logic [31:0]    m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [LW-1:0]  fifo_level;
  logic           overflow;
  logic [CW-1:0]  drop_cnt;

  int checks;
  int errors;

  // Model: samples sitting in the FIFO, plus the second half of an accepted
  // pair that reaches the FIFO one cycle after its strobe.
  logic [31:0] mFifo[$];
  logic [31:0] mPendingB;
  bit          mPending;
  bit          mOverflow;
  int          mDrops;
  int          maxLevel;

  adapter_dl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .iq_rx_i(iq_rx_i), .iq_rx_q(iq_rx_q), .iq_rx_valid(iq_rx_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mFifo.delete();
    mPending  = 0;
    mPendingB = '0;
    mOverflow = 0;
    mDrops    = 0;
  endtask

  task automatic modelDrop();
    mOverflow = 1;
    if (mDrops < (1 << CW) - 1) mDrops++;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic modelStep();
    int lvl;
    lvl = mFifo.size();
    if (lvl > 0 && m_axis_tready) void'(mFifo.pop_front());
    if (mPending) begin
      mFifo.push_back(mPendingB);
      mPending = 0;
      if (iq_rx_valid) modelDrop();
    end else if (iq_rx_valid) begin
      if (lvl <= DEPTH - 2) begin
        mFifo.push_back({iq_rx_q[15:0], iq_rx_i[15:0]});
        mPendingB = {iq_rx_q[31:16], iq_rx_i[31:16]};
        mPending  = 1;
      end else begin
        modelDrop();
      end
    end
  endtask

  task automatic compareAll();
    int n;
    n = mFifo.size();
    if (n > maxLevel) maxLevel = n;
    checkOutput("level", 32'(fifo_level), 32'(n));
    checkOutput("tvalid", 32'(m_axis_tvalid), 32'(n != 0));
    if (n != 0) checkOutput("tdata", m_axis_tdata, mFifo[0]);
    checkOutput("overflow", 32'(overflow), 32'(mOverflow));
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDrops));
  endtask

  // Called at a falling edge: drive one cycle of inputs, cross the rising
  // edge, and compare at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] q,
                               input logic rdy);
    iq_rx_valid   = v;
    iq_rx_i       = i;
    iq_rx_q       = q;
    m_axis_tready = rdy;
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic applyReset();
    #2;
    rst         = 1'b1;
    iq_rx_valid = 1'b0;
    #1;
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_tdata", m_axis_tdata, 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    maxLevel = 0;
    rst = 1'b1;
    iq_rx_i = '0;
    iq_rx_q = '0;
    iq_rx_valid = 1'b0;
    m_axis_tready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    applyReset();

    // Single strobe: A then B on consecutive beats.
    applyStimulus(1'b1, 32'h2222_1111, 32'h4444_3333, 1'b1);
    checkOutput("single_a", m_axis_tdata, 32'h3333_1111);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("single_b", m_axis_tdata, 32'h4444_2222);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("single_empty", 32'(m_axis_tvalid), 32'd0);
    checkOutput("single_ovf", 32'(overflow), 32'd0);

    // Fill with tready low, then one more strobe must be dropped.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 32'h0B00_0A00 + 32'(s), 32'hD000_C000 + 32'(s), 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0);
    end
    checkOutput("full_level", 32'(fifo_level), 32'd8);
    checkOutput("full_head", m_axis_tdata, 32'hC000_0A00);
    applyStimulus(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    checkOutput("full_drop_level", 32'(fifo_level), 32'd8);
    checkOutput("full_drop_ovf", 32'(overflow), 32'd1);
    checkOutput("full_drop_cnt", 32'(drop_cnt), 32'd1);

    // Drain all eight entries.
    for (int k = 0; k < 9; k++) applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("drain_empty", 32'(m_axis_tvalid), 32'd0);

    // Back-to-back strobes: second one is lost.
    applyStimulus(1'b1, 32'h5555_6666, 32'h7777_8888, 1'b1);
    applyStimulus(1'b1, 32'hAAAA_BBBB, 32'hCCCC_DDDD, 1'b1);
    checkOutput("b2b_second_b", m_axis_tdata, 32'h7777_5555);
    checkOutput("b2b_drop_cnt", 32'(drop_cnt), 32'd2);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, '0, 1'b1);

    // Strobes every two cycles with a ready sink.
    maxLevel = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, $urandom, $urandom, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b1);
    end
    checkOutput("steady_max_level", 32'(maxLevel <= 2), 32'd1);
    checkOutput("steady_no_drop", 32'(drop_cnt), 32'd2);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, '0, 1'b1);

    // Reset while a B is pending and three samples are buffered.
    applyStimulus(1'b1, $urandom, $urandom, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, $urandom, $urandom, 1'b0);
    checkOutput("pre_rst_level", 32'(fifo_level), 32'd3);
    applyReset();
    applyStimulus(1'b1, 32'h2222_1111, 32'h4444_3333, 1'b1);
    checkOutput("post_rst_a", m_axis_tdata, 32'h3333_1111);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("post_rst_b", m_axis_tdata, 32'h4444_2222);

    // Random traffic, including too-close strobes and occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset();
      end else begin
        applyStimulus(($urandom_range(0, 2) == 0), $urandom, $urandom,
                      ($urandom_range(0, 3) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adapter_dl.md
Name: adapter_dl

Overview:
- Downlink counterpart of the uplink DDC-to-CPRI adapter.
- Takes CPRI receive IQ words, each packing two consecutive 16-bit complex samples, and unpacks them into a one-sample-per-beat AXI-Stream feeding the DUC.
- Buffers samples in a small FIFO so the DUC can apply backpressure; reports overflow.

Parameters:
- FIFO_DEPTH, 8, sample FIFO depth; power of two, >= 4.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- iq_rx_i  input  32  I halves: [15:0] = sample A, [31:16] = sample B.
- iq_rx_q  input  32  Q halves: [15:0] = sample A, [31:16] = sample B.
- iq_rx_valid  input  1  one-cycle strobe; iq_rx_i/q valid this cycle.
- m_axis_tdata  output  32  {Q[15:0], I[15:0]} of the head sample.
- m_axis_tvalid  output  1  FIFO non-empty.
- m_axis_tready  input  1  DUC accepts the beat.
- fifo_level  output  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set on any dropped pair.
- drop_cnt  output  CNT_W  saturating count of dropped strobes.

Behaviour:
- Reset (asynchronous assert, release on clk): FIFO empty, pointers 0, FSM in IDLE, holding register 0, m_axis_tvalid=0, m_axis_tdata=0, fifo_level=0, overflow=0, drop_cnt=0. Reset mid-operation discards all buffered and pending samples.
- Sample packing:
  - Sample A = {iq_rx_q[15:0], iq_rx_i[15:0]}.
  - Sample B = {iq_rx_q[31:16], iq_rx_i[31:16]}.
  - Output order is always A then B.
- FSM, two states:
  - IDLE:
    - On iq_rx_valid with registered level <= FIFO_DEPTH-2: write A into the FIFO at this edge, latch B into the holding register, go to SECOND.
    - On iq_rx_valid with level > FIFO_DEPTH-2: drop the whole pair (A and B), set overflow, drop_cnt+1 (saturating at all-ones), stay in IDLE.
    - No strobe: stay in IDLE.
  - SECOND:
    - Write the holding register (B) into the FIFO, return to IDLE. Space is guaranteed by the IDLE check.
    - If iq_rx_valid also arrives in SECOND: that strobe is dropped (overflow set, drop_cnt+1); the pending B is still written.
- Minimum legal strobe spacing is 2 cycles; closer spacing is an upstream error, handled by the drop rule above.
- Latency: strobe sampled at edge N → A at FIFO head from cycle N+1 (m_axis_tvalid=1 if FIFO was empty) → B written at edge N+1.
- FIFO behaviour:
  - First-word-fall-through: m_axis_tdata = head entry whenever m_axis_tvalid=1.
  - Pop on m_axis_tvalid & m_axis_tready.
  - Simultaneous push and pop in one cycle: level unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop when empty is impossible because tvalid=0.
- AXIS rules:
  - m_axis_tdata stays stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake, except on reset.
- fifo_level is the registered count, updated each edge as level + pushes − pops.
- overflow and drop_cnt clear only on rst.

Test Plan:
- Single strobe, i=0x2222_1111, q=0x4444_3333, tready=1 → beats 0x3333_1111 then 0x4444_2222 on consecutive cycles, first beat at N+1; overflow=0.
- 4 strobes spaced 3 cycles, tready=0 → level=8, tvalid=1, tdata holds first A; 5th strobe → dropped, overflow=1, drop_cnt=1, level stays 8.
- From the full FIFO, raise tready=1 → 8 beats in strobe order with no duplicates or gaps; tvalid=0 after the last beat; pointers have wrapped.
- Strobes on back-to-back cycles → first pair delivered intact, second strobe dropped, drop_cnt=1.
- Steady strobes every 2 cycles with tready=1 → level never exceeds 2, continuous A/B ordering, no drops; push and pop in the same cycle keep the level constant.
- Assert rst while in SECOND with 3 entries buffered → all outputs 0 immediately (asynchronous); after release, first new strobe behaves as in the single-strobe case.
